// File: rtl/muldiv_controller.sv
// muldiv_controller: iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO.
// A 32-step shift-add or restoring-divide datapath runs on operand magnitudes.
// The FIX state applies the signs and writes HI/LO. Stall is raised to the
// hazard unit while an operation is in flight.
module muldiv_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hilo_read,
  input  logic             hilo_write,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      count_reg;
  logic [1:0]         op_reg;
  logic [WIDTH-1:0]   opnd_reg;      // multiplicand (mult) or divisor (div) magnitude
  logic [WIDTH-1:0]   rs_orig_reg;   // original dividend, returned in HI on divide-by-zero
  logic [2*WIDTH-1:0] acc_reg;
  logic               neg_q_reg;     // product/quotient must be negated
  logic               neg_r_reg;     // remainder takes the dividend's negative sign
  logic               div_zero_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;

  logic               accept;
  logic               is_signed;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign accept    = (state_reg == IDLE) && start;
  assign is_signed = ~op[0];
  assign rs_mag    = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_mag    = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  // One shift-add step: add multiplicand when the multiplier LSB is set, then shift right.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

  // One restoring-divide step: bring the next dividend bit into the partial remainder
  // and keep the difference only if it did not borrow.
  assign div_diff = {1'b0, acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]} - {2'b00, opnd_reg};
  assign div_ok   = ~div_diff[WIDTH+1];
  assign rem_new  = div_ok ? div_diff[WIDTH-1:0] : acc_reg[2*WIDTH-2:WIDTH-1];
  assign div_next = {rem_new, acc_reg[WIDTH-2:0], div_ok};

  assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;
  assign quot_fix = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem_fix  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count_reg == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs to the hazard unit and the register file path
  always_comb begin
    busy  = (state_reg != IDLE);
    stall = busy & (start | hilo_read | hilo_write);
    done  = done_reg;
    hi    = hi_reg;
    lo    = lo_reg;
  end

  // Operand latch and iterative datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg    <= '0;
      op_reg       <= '0;
      opnd_reg     <= '0;
      rs_orig_reg  <= '0;
      acc_reg      <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
    end else if (accept) begin
      count_reg    <= CW'(WIDTH - 1);
      op_reg       <= op;
      opnd_reg     <= op[1] ? rt_mag : rs_mag;
      acc_reg      <= {{WIDTH{1'b0}}, (op[1] ? rs_mag : rt_mag)};
      rs_orig_reg  <= rs_val;
      neg_q_reg    <= is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
      neg_r_reg    <= is_signed & rs_val[WIDTH-1];
      div_zero_reg <= (rt_val == '0);
    end else if (state_reg == RUN) begin
      count_reg <= count_reg - 1'b1;
      acc_reg   <= op_reg[1] ? div_next : mul_next;
    end
  end

  // HI/LO ownership: results land in FIX, MTHI/MTLO only when idle and not issuing
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg   <= '0;
      lo_reg   <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= (state_reg == FIX);
      if (state_reg == FIX) begin
        if (!op_reg[1]) begin
          hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
          lo_reg <= prod_fix[WIDTH-1:0];
        end else if (div_zero_reg) begin
          hi_reg <= rs_orig_reg;
          lo_reg <= '1;
        end else begin
          hi_reg <= rem_fix;
          lo_reg <= quot_fix;
        end
      end else if (state_reg == IDLE && !start && hilo_write) begin
        if (hilo_sel) hi_reg <= wdata;
        else          lo_reg <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_controller.sv
// Self-checking bench for muldiv_controller: expected HI/LO pairs are pushed to a
// scoreboard queue at issue and popped when done pulses.
module tb_muldiv_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        hilo_read, hilo_write, hilo_sel;
  logic [31:0] wdata;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [63:0] sb_q[$];

  muldiv_controller #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .hilo_read(hilo_read), .hilo_write(hilo_write), .hilo_sel(hilo_sel), .wdata(wdata),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model using native 64-bit arithmetic; returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      2'b00: model = 64'(sa * sb);
      2'b01: model = ua * ub;
      2'b10: begin
        if (b == 32'h0) model = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          model = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) model = {a, 32'hFFFFFFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          model = {ur[31:0], uq[31:0]};
        end
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the scoreboard and compare against the DUT's HI/LO (called in the done cycle).
  task automatic sb_check(input string name);
    logic [63:0] exp;
    total_cnt++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s: done pulsed with empty scoreboard, hi=%h lo=%h", name, hi, lo);
    end else begin
      exp = sb_q.pop_front();
      if ({hi, lo} !== exp)
        $display("FAIL %s: got hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, exp[63:32], exp[31:0]);
      else begin
        pass_cnt++;
        $display("txn %s: hi=%h lo=%h", name, hi, lo);
      end
    end
  endtask

  // Issue one op in IDLE and wait (bounded) for done.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int n;
    sb_q.push_back(exp);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    if (!done) begin
      total_cnt++;
      $display("FAIL %s: timeout waiting for done, got done=0 expected done=1", name);
      void'(sb_q.pop_front());
    end else begin
      sb_check(name);
      total_cnt++;
      if (n !== 34) $display("FAIL %s_latency: got %0d cycles expected 34", name, n);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    hilo_read = 1'b0; hilo_write = 1'b0; hilo_sel = 1'b0; wdata = '0;
    repeat (3) tick();
    total_cnt++;
    if ({busy, stall, done, hi, lo} !== 67'h0)
      $display("FAIL reset_state: got busy=%b stall=%b done=%b hi=%h lo=%h expected all 0", busy, stall, done, hi, lo);
    else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    logic busy_bad, done_bad;
    busy_bad = 1'b0; done_bad = 1'b0;
    sb_q.push_back({32'hFFFFFFFE, 32'h00000001});
    op = 2'b01; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF; start = 1'b1;
    if (busy || done) busy_bad = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      tick();
      start = 1'b0;
      if (busy !== (k <= 33)) busy_bad = 1'b1;
      if (done !== (k == 34)) done_bad = 1'b1;
      if (k == 34) sb_check("multu_max");
    end
    total_cnt++;
    if (busy_bad) $display("FAIL busy_window: got busy outside cycles 1..33 expected busy only in 1..33");
    else pass_cnt++;
    total_cnt++;
    if (done_bad) $display("FAIL done_pulse: got done outside cycle 34 expected single pulse at cycle 34");
    else pass_cnt++;
  endtask

  task automatic test_arith();
    run_op("mult_neg3x7", 2'b00, 32'hFFFFFFFD, 32'd7, {32'hFFFFFFFF, 32'hFFFFFFEB});
    run_op("div_neg7d2", 2'b10, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("divu_100d0", 2'b11, 32'd100, 32'd0, {32'd100, 32'hFFFFFFFF});
    run_op("div_min_dm1", 2'b10, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
    run_op("div_by0_signed", 2'b10, 32'hFFFFFF00, 32'd0, {32'hFFFFFF00, 32'hFFFFFFFF});
    for (int i = 0; i < 6; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom();
      b = (i == 2) ? 32'd1 : $urandom() >> $urandom_range(0, 30);
      run_op("random", o, a, b, model(o, a, b));
    end
  endtask

  task automatic test_stall_read();
    logic stall_bad;
    stall_bad = 1'b0;
    sb_q.push_back({32'd1, 32'd3});
    op = 2'b11; rs_val = 32'd10; rt_val = 32'd3; start = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      tick();
      start = 1'b0;
      if (k >= 2) begin
        hilo_read = 1'b1;
        #0;
        #1;
        if (stall !== (k <= 33)) stall_bad = 1'b1;
      end
      if (k == 34) sb_check("divu_10d3_read");
    end
    hilo_read = 1'b0;
    total_cnt++;
    if (stall_bad) $display("FAIL read_stall: got stall outside cycles 2..33 expected stall in 2..33 only");
    else pass_cnt++;
    tick();
  endtask

  task automatic test_hilo_write();
    logic hold_bad;
    hold_bad = 1'b0;
    hilo_write = 1'b1; hilo_sel = 1'b0; wdata = 32'h1234;
    tick();
    hilo_write = 1'b0;
    total_cnt++;
    if (lo !== 32'h1234) $display("FAIL mtlo: got lo=%h expected 00001234", lo);
    else pass_cnt++;
    hilo_write = 1'b1; hilo_sel = 1'b1; wdata = 32'h55AA;
    tick();
    hilo_write = 1'b0;
    total_cnt++;
    if (hi !== 32'h55AA) $display("FAIL mthi: got hi=%h expected 000055aa", hi);
    else pass_cnt++;
    // MTHI arriving during a mult must wait until the mult has finished.
    sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
    op = 2'b00; rs_val = 32'hFFFFFFFD; rt_val = 32'd7; start = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      tick();
      start = 1'b0;
      if (k == 5) begin
        hilo_write = 1'b1; hilo_sel = 1'b1; wdata = 32'hDEADBEEF;
        #1;
        total_cnt++;
        if (stall !== 1'b1) $display("FAIL mthi_busy_stall: got stall=%b expected 1", stall);
        else pass_cnt++;
      end
      if (k >= 6 && k <= 33 && hi !== 32'h55AA) hold_bad = 1'b1;
      if (k == 34) begin
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL mthi_idle_stall: got stall=%b expected 0", stall);
        else pass_cnt++;
        sb_check("mult_with_mthi");
      end
      if (k == 35) begin
        hilo_write = 1'b0;
        total_cnt++;
        if (hi !== 32'hDEADBEEF || lo !== 32'hFFFFFFEB)
          $display("FAIL mthi_after: got hi=%h lo=%h expected hi=deadbeef lo=ffffffeb", hi, lo);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (hold_bad) $display("FAIL mthi_hold: got hi changed while busy expected 000055aa");
    else pass_cnt++;
  endtask

  task automatic test_start_write_conflict();
    sb_q.push_back({32'h0, 32'd6});
    op = 2'b01; rs_val = 32'd2; rt_val = 32'd3; start = 1'b1;
    hilo_write = 1'b1; hilo_sel = 1'b0; wdata = 32'hABCD; hilo_read = 1'b1;
    #1;
    total_cnt++;
    if (stall !== 1'b0) $display("FAIL idle_read_start_stall: got stall=%b expected 0", stall);
    else pass_cnt++;
    tick();
    start = 1'b0; hilo_write = 1'b0; hilo_read = 1'b0;
    total_cnt++;
    if (lo !== 32'hFFFFFFEB) $display("FAIL write_dropped: got lo=%h expected ffffffeb", lo);
    else pass_cnt++;
    for (int k = 2; k <= 34; k++) begin
      tick();
      if (k == 34) sb_check("multu_2x3_conflict");
    end
  endtask

  task automatic test_back_to_back();
    logic stall_bad;
    stall_bad = 1'b0;
    sb_q.push_back({32'h0, 32'd30});
    op = 2'b01; rs_val = 32'd5; rt_val = 32'd6; start = 1'b1;
    tick();
    op = 2'b11; rs_val = 32'd100; rt_val = 32'd7;
    for (int k = 1; k <= 33; k++) begin
      if (stall !== 1'b1) stall_bad = 1'b1;
      tick();
    end
    total_cnt++;
    if (stall_bad) $display("FAIL b2b_stall: got stall=0 while busy expected 1 in cycles 1..33");
    else pass_cnt++;
    total_cnt++;
    if (stall !== 1'b0 || done !== 1'b1) $display("FAIL b2b_cycle34: got stall=%b done=%b expected stall=0 done=1", stall, done);
    else pass_cnt++;
    sb_check("b2b_first");
    sb_q.push_back({32'd2, 32'd14});
    tick();
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b in cycle 35 expected 1", busy);
    else pass_cnt++;
    for (int k = 36; k <= 68; k++) tick();
    total_cnt++;
    if (done !== 1'b1) $display("FAIL b2b_second_done: got done=%b at cycle 68 expected 1", done);
    else pass_cnt++;
    sb_check("b2b_second");
    tick();
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    seen_done = 1'b0;
    op = 2'b00; rs_val = 32'd3; rt_val = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 10; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
      $display("FAIL reset_mid: got busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=0", busy, hi, lo);
    else pass_cnt++;
    for (int k = 0; k < 40; k++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    total_cnt++;
    if (seen_done) $display("FAIL reset_mid_done: got done pulse for discarded op expected none");
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_stall_read();
    test_hilo_write();
    test_start_write_conflict();
    test_back_to_back();
    test_reset_mid();
    total_cnt++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
